// File: rtl/ssd_pkg.sv
// +--------------------------------------------------------------------+
// | ssd_pkg: shared constants, segment table and state type for the    |
// |          seven-segment scanner.                                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments, bit6 = a ... bit0 = g, indexed by hex nibble
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssd_seg_decode.sv
// +--------------------------------------------------------------------+
// | ssd_seg_decode: combinational hex nibble to active-low segments.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

`default_nettype wire

// File: rtl/ssd_scanner.sv
// +--------------------------------------------------------------------+
// | ssd_scanner: round-robin common-anode 7-segment driver with a      |
// |              blanking gap at the start of every digit slot.        |
// | Option macro: LEADING_ZERO_BLANK_EN (suppress leading zeros).      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module ssd_scanner
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    frame_tick
);

  localparam int CNT_W = clog2(REFRESH_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  state_t                  r_state;
  logic [4*NUM_DIGITS-1:0] r_pending;
  logic [4*NUM_DIGITS-1:0] r_shown;

  logic                    w_slot_end;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [NUM_DIGITS-1:0]   w_keep;
  logic                    w_lit;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
  assign w_nib      = r_shown[{r_idx, 2'b00} +: 4];
  assign w_sel      = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

  ssd_seg_decode u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit stays lit only if it or some higher digit is nonzero; digit 0 always lit
  always_comb begin
    logic v_seen;
    v_seen = 1'b0;
    w_keep = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      v_seen    = v_seen | (|r_shown[i*4 +: 4]);
      w_keep[i] = v_seen;
    end
    w_keep[0] = 1'b1;
  end
`else
  assign w_keep = '1;
`endif

  assign w_lit = (r_state == S_DRIVE) && digit_en[r_idx] && w_keep[r_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_state    <= S_BLANK;
      r_pending  <= '0;
      r_shown    <= '0;
      anode      <= '1;
      cathode    <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_wrap;

      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      case (r_state)
        S_BLANK: if (r_cnt == BLANK_LAST) r_state <= S_DRIVE;
        S_DRIVE: if (w_slot_end)          r_state <= S_BLANK;
        default:                          r_state <= S_BLANK;
      endcase

      if (load) r_pending <= value;
      // Shown only advances at frame wrap so a frame never mixes two values
      if (w_wrap) r_shown <= load ? value : r_pending;

      anode   <= w_lit ? ~w_sel : '1;
      cathode <= w_lit ? w_seg  : SEG_BLANK;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssd_scanner.sv
// +--------------------------------------------------------------------+
// | tb_ssd_scanner: directed checks of scan timing, load/wrap, enable, |
// |                 reset abort and decode for a 4-digit, 8-cycle slot.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ssd_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        frame_tick;

  int n_vec = 0;
  int n_err = 0;
  int n     = 0;   // edges since the last reset-release edge

  localparam logic [3:0] START_AN [11] = '{
    4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD
  };

  ssd_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .digit_en   (digit_en),
    .anode      (anode),
    .cathode    (cathode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n=%0d", n);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) n = 0;
    else       n = n + 1;
    #1;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 2000) begin
      tick();
      guard++;
    end
    if (n != target) check_val("run_to", n, target);
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_cat);
    check_val({tag, "_an"}, {28'd0, anode}, {28'd0, exp_an});
    check_val({tag, "_cat"}, {25'd0, cathode}, {25'd0, exp_cat});
  endtask

  task automatic do_load(input int at, input logic [15:0] v);
    run_to(at - 1);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    value = 16'hFFFF;
  endtask

  // Fresh state after reset: shown=0, so every lit digit shows "0"
  task automatic check_startup(input string tag);
    for (int i = 0; i < 11; i++) begin
      tick();
      check_out(tag, START_AN[i], (START_AN[i] == 4'hF) ? 7'b1111111 : 7'b0000001);
    end
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    digit_en = 4'hF;

    // Reset held
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("rst", 4'hF, 7'b1111111);
      check_val("rst_ft", {31'd0, frame_tick}, 32'd0);
    end
    reset = 1'b0;

    // Start-up slot timing and frame period
    check_startup("s1");
    run_to(31); check_val("s1_ft31", {31'd0, frame_tick}, 32'd0);
    run_to(32); check_val("s1_ft32", {31'd0, frame_tick}, 32'd1);
    run_to(33); check_val("s1_ft33", {31'd0, frame_tick}, 32'd0);

    // Mid-frame load waits for the wrap
    do_load(45, 16'h1234);
    run_to(60); check_out("s2_old_d3", 4'b0111, 7'b0000001);
    run_to(64); check_val("s2_ft64", {31'd0, frame_tick}, 32'd1);
    run_to(67); check_out("s2_d0", 4'b1110, 7'b1001100);
    run_to(75); check_out("s2_d1", 4'b1101, 7'b0000110);
    run_to(83); check_out("s2_d2", 4'b1011, 7'b0010010);
    run_to(91); check_out("s2_d3", 4'b0111, 7'b1001111);
    run_to(95); check_val("s2_ft95", {31'd0, frame_tick}, 32'd0);
    run_to(96); check_val("s2_ft96", {31'd0, frame_tick}, 32'd1);

    // Digits 1 and 3 disabled for three frames
    digit_en = 4'b0101;
    while (n < 192) begin
      tick();
      check_val("s3_mask", {28'd0, anode & 4'b1010}, 32'hA);
      if (n % 32 == 0) check_val("s3_ft", {31'd0, frame_tick}, 32'd1);
      if (n == 147) check_out("s3_d2", 4'b1011, 7'b0010010);
      if (n == 139) check_out("s3_d1", 4'b1111, 7'b1111111);
    end
    digit_en = 4'hF;

    // Reset while digit 2 is driving
    run_to(211); check_out("s4_pre", 4'b1011, 7'b0010010);
    reset = 1'b1;
    tick();
    check_out("s4_rst", 4'hF, 7'b1111111);
    reset = 1'b0;
    check_startup("s4");

    // Load on the wrap cycle goes straight to shown; later load waits a frame
    do_load(32, 16'hABCD);
    check_val("s5_ft32", {31'd0, frame_tick}, 32'd1);
    run_to(35); check_out("s5_d0", 4'b1110, 7'b1000010);
    run_to(43); check_out("s5_d1", 4'b1101, 7'b1110010);
    do_load(45, 16'hEF01);
    run_to(51); check_out("s5_d2", 4'b1011, 7'b1100000);
    run_to(59); check_out("s5_d3", 4'b0111, 7'b0001000);
    run_to(67); check_out("s5_n0", 4'b1110, 7'b1001111);
    run_to(75); check_out("s5_n1", 4'b1101, 7'b0000001);
    run_to(83); check_out("s5_n2", 4'b1011, 7'b0111000);
    run_to(91); check_out("s5_n3", 4'b0111, 7'b0110000);

    // Leading zeros
    do_load(100, 16'h0070);
    run_to(131); check_out("s6_d0", 4'b1110, 7'b0000001);
    run_to(139); check_out("s6_d1", 4'b1101, 7'b0001111);
`ifdef LEADING_ZERO_BLANK_EN
    run_to(147); check_out("s6_d2", 4'b1111, 7'b1111111);
    run_to(155); check_out("s6_d3", 4'b1111, 7'b1111111);
`else
    run_to(147); check_out("s6_d2", 4'b1011, 7'b0000001);
    run_to(155); check_out("s6_d3", 4'b0111, 7'b0000001);
`endif
    do_load(170, 16'h0000);
    run_to(195); check_out("s6_z0", 4'b1110, 7'b0000001);
`ifdef LEADING_ZERO_BLANK_EN
    run_to(203); check_out("s6_z1", 4'b1111, 7'b1111111);
    run_to(211); check_out("s6_z2", 4'b1111, 7'b1111111);
    run_to(219); check_out("s6_z3", 4'b1111, 7'b1111111);
`else
    run_to(203); check_out("s6_z1", 4'b1101, 7'b0000001);
    run_to(211); check_out("s6_z2", 4'b1011, 7'b0000001);
    run_to(219); check_out("s6_z3", 4'b0111, 7'b0000001);
`endif

    // Remaining decode entries
    do_load(230, 16'h5689);
    run_to(259); check_out("s7_d0", 4'b1110, 7'b0000100);
    run_to(267); check_out("s7_d1", 4'b1101, 7'b0000000);
    run_to(275); check_out("s7_d2", 4'b1011, 7'b0100000);
    run_to(283); check_out("s7_d3", 4'b0111, 7'b0100100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
